// File: rtl/sv_psum_collector.sv
// sv_psum_collector: sums PE-array column psums over passes, queues results.
// Optional PSUM_SAT_EN: saturate lane sums on overflow instead of wrapping.
module sv_psum_collector #(
  parameter int PE_WIDTH   = 16,
  parameter int NUM_COLS   = 3,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_PASSES = 4,
  parameter int OUT_DEPTH  = 4,
  localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_COLS*PE_WIDTH-1:0]  psum_in,
  input  logic                          psum_valid,
  output logic                          psum_ready,
  input  logic                          flush,
  output logic [NUM_COLS*ACC_WIDTH-1:0] out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PW-1:0]                 pass_idx,
  output logic                          ovf
);

  localparam int AW = $clog2(OUT_DEPTH);
  localparam int DW = NUM_COLS*ACC_WIDTH;
  localparam logic [PW-1:0] LAST = PW'(NUM_PASSES-1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(OUT_DEPTH);
`ifdef PSUM_SAT_EN
  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FLUSH
  } state_t;

  state_t state, state_nxt;

  logic [ACC_WIDTH-1:0] acc [NUM_COLS];
  logic [DW-1:0]        mem [OUT_DEPTH];
  logic [DW-1:0]        sum_vec;
  logic [DW-1:0]        acc_vec;
  logic [DW-1:0]        push_data;
  logic [NUM_COLS-1:0]  lane_ovf;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 full;
  logic                 accept;
  logic                 last;
  logic                 push;
  logic                 pop;

  assign full       = (count == FULL_CNT);
  assign psum_ready = (state != FLUSH) && !full;
  assign accept     = psum_valid && psum_ready;
  assign last       = (pass_idx == LAST);
  assign out_valid  = (count != '0);
  assign pop        = out_valid && out_ready;
  assign out_data   = mem[rd_ptr];

  for (genvar k = 0; k < NUM_COLS; k++) begin : g_lane
    logic signed [PE_WIDTH-1:0]  p;
    logic signed [ACC_WIDTH-1:0] s;
    logic signed [ACC_WIDTH-1:0] b;
    logic signed [ACC_WIDTH-1:0] raw;

    assign p   = psum_in[k*PE_WIDTH +: PE_WIDTH];
    assign s   = ACC_WIDTH'(p);
    // pass 0 starts a fresh sum, so the old acc never contributes
    assign b   = (pass_idx == '0) ? '0 : acc[k];
    assign raw = b + s;
    assign lane_ovf[k] = (b[ACC_WIDTH-1] == s[ACC_WIDTH-1]) &&
                         (raw[ACC_WIDTH-1] != b[ACC_WIDTH-1]);
`ifdef PSUM_SAT_EN
    assign sum_vec[k*ACC_WIDTH +: ACC_WIDTH] =
      lane_ovf[k] ? (b[ACC_WIDTH-1] ? SMIN : SMAX) : raw;
`else
    assign sum_vec[k*ACC_WIDTH +: ACC_WIDTH] = raw;
`endif
    assign acc_vec[k*ACC_WIDTH +: ACC_WIDTH] = acc[k];
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = sum_vec;
    unique case (state)
      IDLE: begin
        if (accept) begin
          push = last;
          if (!last) state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (accept && last) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end else if (flush) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        push_data = acc_vec;
        if (!full) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_idx <= '0;
      ovf      <= 1'b0;
      for (int k = 0; k < NUM_COLS; k++) acc[k] <= '0;
    end else begin
      if (accept) begin
        for (int k = 0; k < NUM_COLS; k++)
          acc[k] <= sum_vec[k*ACC_WIDTH +: ACC_WIDTH];
        pass_idx <= last ? '0 : pass_idx + PW'(1);
        if (|lane_ovf) ovf <= 1'b1;
      end
      if (state == FLUSH && !full) pass_idx <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        (push && !pop): count <= count + (AW+1)'(1);
        (pop && !push): count <= count - (AW+1)'(1);
        default:        count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sv_psum_collector.sv
// tb_sv_psum_collector: table vectors + scoreboard for sv_psum_collector.
// Second instance with ACC_WIDTH=16 exercises the overflow path.
module tb_sv_psum_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] psum_in;
  logic        psum_valid;
  logic        psum_ready;
  logic        flush;
  logic [95:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  pass_idx;
  logic        ovf;

  logic [47:0] p2_in;
  logic        p2_valid;
  logic        p2_ready;
  logic [47:0] o2_data;
  logic        o2_valid;
  logic [1:0]  p2_idx;
  logic        ovf2;

  int total = 0;
  int bad   = 0;
  logic [95:0] q[$];

  typedef struct {
    logic [47:0] b[4];
    logic [95:0] e;
  } vec_t;

  vec_t tbl[4];

  always #5 clk = ~clk;

  sv_psum_collector dut (
    .clk(clk), .rst(rst),
    .psum_in(psum_in), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .pass_idx(pass_idx), .ovf(ovf)
  );

  sv_psum_collector #(.PE_WIDTH(16), .ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .psum_in(p2_in), .psum_valid(p2_valid), .psum_ready(p2_ready),
    .flush(1'b0),
    .out_data(o2_data), .out_valid(o2_valid), .out_ready(1'b1),
    .pass_idx(p2_idx), .ovf(ovf2)
  );

  function automatic logic [47:0] pk3(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [95:0] pw3(input int a, input int b, input int c);
    return {32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic chk(input string nm, input logic [95:0] act,
                     input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h want none", out_data);
      end else begin
        chk("out_data", out_data, q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [47:0] v);
    int n = 0;
    psum_in    = v;
    psum_valid = 1'b1;
    while (!psum_ready && n < 50) begin
      tick(1);
      n++;
    end
    if (!psum_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: ready=0 want 1");
    end else begin
      tick(1);
    end
    psum_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      tick(1);
      n++;
    end
    chk("drain_left", 96'(q.size()), 96'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim did not finish");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2;
    logic [15:0] ovf_exp;

    tbl[0].b[0] = pk3(1, 2, 3);
    tbl[0].b[1] = pk3(1, 2, 3);
    tbl[0].b[2] = pk3(1, 2, 3);
    tbl[0].b[3] = pk3(1, 2, 3);
    tbl[0].e    = pw3(4, 8, 12);
    tbl[1].b[0] = pk3(-5, 100, -32768);
    tbl[1].b[1] = pk3(3, 200, -32768);
    tbl[1].b[2] = pk3(-1, 300, -32768);
    tbl[1].b[3] = pk3(-7, 400, -32768);
    tbl[1].e    = {32'hFFFE0000, 32'd1000, 32'hFFFFFFF6};
    tbl[2].b[0] = pk3(32767, 0, 7);
    tbl[2].b[1] = pk3(32767, 0, -7);
    tbl[2].b[2] = pk3(32767, 0, 7);
    tbl[2].b[3] = pk3(32767, 0, -7);
    tbl[2].e    = pw3(131068, 0, 0);
    tbl[3].b[0] = pk3(-1, 1, 1000);
    tbl[3].b[1] = pk3(-1, -2, -3000);
    tbl[3].b[2] = pk3(-1, 3, 500);
    tbl[3].b[3] = pk3(-1, -4, 0);
    tbl[3].e    = pw3(-4, -2, -1500);

`ifdef PSUM_SAT_EN
    ovf_exp = 16'h7FFF;
`else
    ovf_exp = 16'h8000;
`endif

    rst        = 1'b0;
    psum_in    = '0;
    psum_valid = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    p2_in      = '0;
    p2_valid   = 1'b0;
    tick(2);
    chk("rst_ready", psum_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", pass_idx, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b1;
    tick(1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 3) begin
          chk("pre_valid", out_valid, 0);
          q.push_back(tbl[r].e);
        end
        send(tbl[r].b[i]);
        if (i == 0) chk("idx_step", pass_idx, 1);
      end
      chk("lat_valid", out_valid, 1);
      chk("idx_wrap", pass_idx, 0);
    end
    drain();

    out_ready = 1'b0;
    a0 = 0; a1 = 0; a2 = 0;
    for (int i = 0; i < 16; i++) begin
      a0 += i + 1;
      a1 += 100 + i;
      a2 -= i + 1;
      if (i % 4 == 3) begin
        q.push_back(pw3(a0, a1, a2));
        a0 = 0; a1 = 0; a2 = 0;
      end
      send(pk3(i + 1, 100 + i, -(i + 1)));
    end
    chk("bp_ready", psum_ready, 0);
    chk("bp_head", out_data, q[0]);
    tick(2);
    chk("bp_hold", out_data, q[0]);
    chk("bp_stall", psum_ready, 0);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("bp_reready", psum_ready, 1);
    out_ready = 1'b1;
    drain();

    send(pk3(10, 10, 10));
    send(pk3(10, 10, 10));
    chk("fl_idx2", pass_idx, 2);
    flush = 1'b1;
    q.push_back(pw3(20, 20, 20));
    tick(1);
    flush = 1'b0;
    chk("fl_ready", psum_ready, 0);
    tick(1);
    chk("fl_idx0", pass_idx, 0);
    chk("fl_valid", out_valid, 1);
    drain();

    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(3);
    chk("idle_flush", out_valid, 0);
    chk("idle_ready", psum_ready, 1);

    send(pk3(2, 3, 4));
    send(pk3(2, 3, 4));
    send(pk3(2, 3, 4));
    flush = 1'b1;
    q.push_back(pw3(8, 12, 16));
    send(pk3(2, 3, 4));
    flush = 1'b0;
    tick(3);
    chk("ff_idx", pass_idx, 0);
    chk("ff_ready", psum_ready, 1);
    chk("ff_valid", out_valid, 0);
    drain();

    chk("o16_ready", p2_ready, 1);
    p2_valid = 1'b1;
    p2_in    = 48'h7FFF;
    tick(1);
    chk("o16_ovf0", ovf2, 0);
    p2_in = 48'h0001;
    tick(1);
    chk("o16_ovf1", ovf2, 1);
    p2_in = '0;
    tick(2);
    p2_valid = 1'b0;
    chk("o16_valid", o2_valid, 1);
    chk("o16_lane0", o2_data[15:0], ovf_exp);
    chk("o16_idx", p2_idx, 0);
    chk("main_ovf", ovf, 0);
    tick(1);

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(pk3(3, 3, 3));
    send(pk3(9, 9, 9));
    send(pk3(9, 9, 9));
    chk("mr_valid", out_valid, 1);
    chk("mr_idx", pass_idx, 2);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_async_valid", out_valid, 0);
    chk("mr_async_idx", pass_idx, 0);
    chk("mr_async_ready", psum_ready, 1);
    tick(1);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) q.push_back(pw3(4, 4, 4));
      send(pk3(1, 1, 1));
    end
    chk("mr_lat_valid", out_valid, 1);
    drain();
    chk("end_ovf", ovf, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sv_psum_collector.md
# sv_psum_collector

Output stage placed directly downstream of the configurable PE array. Captures the per-column partial-sum vector from the array's bottom row and sign-extends it to an accumulator width. Accumulates it across a programmable number of passes, one per input-channel / kernel-row pass. Completed column sums go into a small output FIFO and drain to the global buffer over a valid/ready handshake.

## Interface
- `PE_WIDTH`, 16, width of each signed psum from the array
- `NUM_COLS`, 3, number of array columns (psum lanes)
- `ACC_WIDTH`, 32, signed accumulator width per lane; must be ≥ `PE_WIDTH`
- `NUM_PASSES`, 4, passes summed per result; ≥ 1
- `OUT_DEPTH`, 4, output FIFO entries; power of two, ≥ 2

- `clk` input 1: single clock, rising edge
- `rst` input 1: reset, asynchronous and active-low
- `psum_in` input `NUM_COLS*PE_WIDTH`: lane k at bits `[k*PE_WIDTH +: PE_WIDTH]`, signed
- `psum_valid` input 1: `psum_in` valid this cycle
- `psum_ready` output 1: collector accepts `psum_in`
- `flush` input 1: single-cycle request to emit the current partial sum early
- `out_data` output `NUM_COLS*ACC_WIDTH`: lane k at `[k*ACC_WIDTH +: ACC_WIDTH]`
- `out_valid` output 1: FIFO head valid
- `out_ready` input 1: consumer takes head
- `pass_idx` output `$clog2(NUM_PASSES)` (min 1 bit): pass number expected next
- `ovf` output 1: sticky; set when any lane overflowed `ACC_WIDTH`; cleared only by reset

## Operation
- An input beat is accepted when `psum_valid && psum_ready`.
- Each lane is sign-extended to `ACC_WIDTH` (s).
  - If `pass_idx==0`: acc ← s.
  - Otherwise: acc ← acc + s.
- Acceptance with `pass_idx==NUM_PASSES-1` is the final pass.
  - The lane results (acc+s, or s when `NUM_PASSES==1`) are pushed to the FIFO.
  - `pass_idx` ← 0. Otherwise `pass_idx` increments.
- FSM, 3 states:
  - `IDLE`: `pass_idx==0`, no partial held. Accept → `ACCUM`, or stay in `IDLE` if it was the final pass.
  - `ACCUM`: partial held. Final-pass accept → `IDLE`. `flush` → `FLUSH`.
  - `FLUSH`: `psum_ready`=0. When the FIFO is not full, push the current acc vector, set `pass_idx` ← 0 and go to `IDLE`.
- `flush` in `IDLE` is ignored.
- `flush` in the same cycle as an accepted beat: the beat is accumulated first, then the flush applies.
  - If that beat was the final pass, the flush is dropped; the result is already pushed.
- `psum_ready` = (state != `FLUSH`) && !fifo_full. It depends only on registers, with no combinational path from `out_ready`.
- FIFO behaviour:
  - Push and pop may occur in the same cycle; count is then unchanged.
  - Pointers wrap modulo `OUT_DEPTH`.
  - Pop occurs when `out_valid && out_ready`.
- Overflow is detected per lane as sign(acc)==sign(s) and sign(sum)!=sign(acc); it sets `ovf`.
- Reset mid-operation discards any partial sum and all FIFO contents.

## Timing
- Reset values:
  - `psum_ready`=1, `out_valid`=0, `out_data`=0, `pass_idx`=0, `ovf`=0.
  - FSM = `IDLE`, FIFO empty.
- Latency: a final-pass accept at edge N produces `out_valid`=1 with the result after edge N (next cycle).
- `FLUSH` takes ≥1 cycle. It pushes at the first edge where the FIFO is not full.
- A full FIFO with a pop at edge N gives `psum_ready`=1 after edge N.
- `out_data` is FIFO-head registered. It holds stable while `out_valid && !out_ready`.
- Throughput: one beat per cycle while the FIFO is not full.

## Configuration
- Macro: `PSUM_SAT_EN`.
- Defined: each lane's add saturates to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) on overflow, and `ovf` is still set.
- Undefined: two's-complement wrap, with `ovf` set.

## Test plan
- Basic accumulation. Defaults, lanes {1,2,3} for 4 passes, `out_ready`=1 → one output {4,8,12}, `out_valid` high 1 cycle after the 4th accept, `pass_idx` back to 0.
- Signed values. Lane0 sequence {-5,+3,-1,-7} → out lane0 = -10 (0xFFFFFFF6).
- Backpressure. `out_ready`=0, 16 beats → 4 results, then `psum_ready`=0. One pop re-asserts `psum_ready` the next cycle. Data arrives in order, unchanged.
- Flush. 2 passes of {10,10,10}, then `flush` → output {20,20,20}, `pass_idx`=0. `flush` while `IDLE` → no output.
- Overflow. `ACC_WIDTH`=16, `PE_WIDTH`=16, lane0 {0x7FFF,0x0001,0,0}:
  - With `PSUM_SAT_EN`: out 0x7FFF, `ovf`=1.
  - Without it: out 0x8000, `ovf`=1.
- Reset mid-operation. Assert `rst` low after 2 passes and with 1 FIFO entry held → `out_valid`=0 asynchronously. After release, 4 passes of {1,1,1} → {4,4,4}.
